// File: rtl/rs_gf_pkg.sv
// GF(2^8) constants, generator coefficients and state encoding shared by the
// Reed-Solomon encoder and decoder blocks.
package rs_gf_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         NPAR    = 4;

  // g(x) = x^4 + G3*x^3 + G2*x^2 + G1*x + G0, roots alpha^0..alpha^3
  localparam logic [7:0] G0 = 8'h40;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [NPAR*8-1:0] GEN_PACKED = {G3, G2, G1, G0};

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } enc_state_t;

  // Shift-and-add multiply, reducing by the field polynomial at each step.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) general multiplier over the 0x11D field.
module gf2m8_multi
  import rs_gf_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/s0_rs_enc.sv
// Systematic RS(N, N-4) encoder: message symbols pass straight through, then
// the four LFSR parity symbols are shifted out behind them.
module s0_rs_enc
  import rs_gf_pkg::*;
#(
  parameter int N = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_par,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int K  = N - NPAR;
  localparam int CW = $clog2(N);

  enc_state_t             r_state;
  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_pcnt;
  logic [NPAR-1:0][7:0]   r_par;
  logic [7:0]             r_out_data;
  logic                   r_out_valid;
  logic                   r_out_par;
  logic                   r_out_last;

  logic                   w_out_en;
  logic                   w_accept;
  logic [7:0]             w_fb;
  logic [NPAR-1:0][7:0]   w_prod;

  assign w_out_en = out_ready | ~r_out_valid;
  assign in_ready = ~rst & (r_state == ST_MSG) & w_out_en;
  assign w_accept = in_valid & in_ready;
  assign w_fb     = in_data ^ r_par[NPAR-1];

  genvar gi;
  generate
    for (gi = 0; gi < NPAR; gi++) begin : g_mul
      gf2m8_multi u_mul (
        .i_a (w_fb),
        .i_b (GEN_PACKED[gi*8 +: 8]),
        .o_p (w_prod[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_MSG;
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_par       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_par   <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_out_en) begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_MSG: begin
          if (w_accept) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
            r_out_par   <= 1'b0;
            r_out_last  <= 1'b0;
            r_par[0]    <= w_prod[0];
            for (int i = 1; i < NPAR; i++) begin
              r_par[i] <= r_par[i-1] ^ w_prod[i];
            end
            if (r_cnt == CW'(K - 1)) begin
              r_state <= ST_PAR;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_PAR: begin
          r_out_data  <= r_par[NPAR-1];
          r_out_valid <= 1'b1;
          r_out_par   <= 1'b1;
          r_out_last  <= (r_pcnt == 2'd3);
          // Zero fill leaves the LFSR clear once the last parity leaves.
          r_par       <= {r_par[NPAR-2:0], 8'h00};
          if (r_pcnt == 2'd3) begin
            r_state <= ST_MSG;
            r_pcnt  <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        default: r_state <= ST_MSG;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_par   = r_out_par;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_s0_rs_enc.sv
// Bench for s0_rs_enc: polynomial-division reference model, syndrome check of
// every received codeword, directed vectors and randomized handshake stress.
module tb_s0_rs_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       iv255, iv8, rdy255, rdy8, ov255, ov8, op255, op8, ol255, ol8;
  logic [7:0] od255, od8;
  logic       in_ready, out_valid, out_par, out_last;
  logic [7:0] out_data;

  assign iv255     = in_valid & ~sel;
  assign iv8       = in_valid & sel;
  assign in_ready  = sel ? rdy8 : rdy255;
  assign out_valid = sel ? ov8  : ov255;
  assign out_data  = sel ? od8  : od255;
  assign out_par   = sel ? op8  : op255;
  assign out_last  = sel ? ol8  : ol255;

  s0_rs_enc #(.N(255)) dut (
    .clk(clk), .rst(rst), .in_valid(iv255), .in_data(in_data), .in_ready(rdy255),
    .out_valid(ov255), .out_data(od255), .out_par(op255), .out_last(ol255),
    .out_ready(out_ready)
  );

  s0_rs_enc #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_data(in_data), .in_ready(rdy8),
    .out_valid(ov8), .out_data(od8), .out_par(op8), .out_last(ol8),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       l;
  } sym_t;

  typedef struct {
    logic [31:0] msg;
    logic [31:0] par;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cur_n, cur_k;
  int         gap_cnt, cw_cnt;
  logic       acc_now;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_par, prev_last;

  sym_t       exp_q[$];
  logic [7:0] msg_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] src_q[$];
  logic [7:0] last_par [4];

  logic [7:0] exp_t [0:511];
  int         log_t [0:255];
  logic [7:0] gp [0:4];
  vec_t       tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  // Codeword evaluated at alpha^j, highest-degree symbol first.
  function automatic logic [7:0] synd(input int j);
    logic [7:0] s;
    logic [7:0] a;
    s = 8'h00;
    a = exp_t[j];
    foreach (rx_q[i]) s = gmul(s, a) ^ rx_q[i];
    return s;
  endfunction

  // Parity = remainder of m(x)*x^4 divided by g(x), by long division.
  task automatic close_msg();
    logic [7:0] dv [0:258];
    for (int i = 0; i < cur_k; i++) dv[i] = msg_q[i];
    for (int i = 0; i < 4; i++) dv[cur_k + i] = 8'h00;
    for (int i = 0; i < cur_k; i++) begin
      logic [7:0] c;
      c = dv[i];
      for (int j = 1; j <= 4; j++) dv[i + j] = dv[i + j] ^ gmul(c, gp[j]);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: dv[cur_k + i], p: 1'b1, l: (i == 3)});
    msg_q.delete();
  endtask

  task automatic monitor();
    acc_now = 1'b0;
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall)
      chk("stall_hold", 32'({out_valid, out_data, out_par, out_last}),
          32'({1'b1, prev_data, prev_par, prev_last}));
    if (!out_valid && exp_q.size() > 0) gap_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_symbol: got %h, expected no output", out_data);
      end else begin
        sym_t e = exp_q.pop_front();
        chk("symbol", 32'({out_data, out_par, out_last}), 32'({e.d, e.p, e.l}));
      end
      rx_q.push_back(out_data);
      if (out_last) begin
        chk("cw_len", 32'(rx_q.size()), 32'(cur_n));
        for (int j = 0; j < 4; j++) chk($sformatf("syndrome_S%0d", j), 32'(synd(j)), 32'h0);
        if (rx_q.size() >= 4)
          for (int i = 0; i < 4; i++) last_par[i] = rx_q[rx_q.size() - 4 + i];
        $display("codeword %0d: N=%0d parity %h %h %h %h", cw_cnt, cur_n,
                 last_par[0], last_par[1], last_par[2], last_par[3]);
        cw_cnt++;
        rx_q.delete();
      end
    end
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    prev_par   = out_par;
    prev_last  = out_last;
    if (in_valid && in_ready) begin
      acc_now = 1'b1;
      exp_q.push_back('{d: in_data, p: 1'b0, l: 1'b0});
      msg_q.push_back(in_data);
      if (msg_q.size() == cur_k) close_msg();
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    monitor();
  endtask

  task automatic stream(input int vpct, input int rpct, output int t);
    int budget;
    budget = (src_q.size() + 8) * 40 + 200;
    t = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && t < budget) begin
      logic v, r;
      v = (src_q.size() > 0) && ($urandom_range(0, 99) < vpct);
      r = ($urandom_range(0, 99) < rpct);
      cycle(v, v ? src_q[0] : 8'h00, r);
      if (acc_now) void'(src_q.pop_front());
      t++;
    end
    chk("stream_within_budget", 32'(t < budget), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic use_dut(input logic s);
    sel        = s;
    cur_n      = s ? 8 : 255;
    cur_k      = cur_n - 4;
    prev_stall = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int x;
    logic [7:0] r8;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = i;
      x = x * 2;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    for (int i = 255; i < 512; i++) exp_t[i] = exp_t[i - 255];
    log_t[0] = 0;

    // g(x) = product of (x + alpha^i), i = 0..3; gp[] holds it highest degree first.
    begin
      logic [7:0] g [0:4];
      g[0] = 8'h01;
      for (int k = 1; k <= 4; k++) g[k] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        r8 = exp_t[i];
        for (int k = 4; k >= 1; k--) g[k] = g[k-1] ^ gmul(g[k], r8);
        g[0] = gmul(g[0], r8);
      end
      for (int j = 0; j <= 4; j++) gp[j] = g[4 - j];
    end

    tbl[0] = '{msg: 32'h00000000, par: 32'h00000000};
    tbl[1] = '{msg: 32'h00000001, par: 32'h0F367840};
    tbl[2] = '{msg: 32'h00000002, par: 32'h1E6CF080};
    tbl[3] = '{msg: 32'h00000003, par: 32'h115A88C0};
    tbl[4] = '{msg: 32'h00000100, par: 32'h6357D2E7};
    tbl[5] = '{msg: 32'h00000101, par: 32'h6C61AAA7};

    gap_cnt = 0;
    cw_cnt  = 0;
    use_dut(1'b0);

    // Reset with in_valid held high: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAB; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("in_ready_during_rst", 32'(in_ready), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_par",   32'(out_par),   32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("idle_after_rst_valid", 32'(out_valid), 32'h0);

    // Zero message, full speed.
    for (int i = 0; i < 251; i++) src_q.push_back(8'h00);
    gap_cnt = 0;
    stream(100, 100, t);
    chk("zero_msg_cycles", 32'(t), 32'(255 + 1));
    chk("zero_msg_parity", {last_par[0], last_par[1], last_par[2], last_par[3]}, 32'h0);
    chk("zero_msg_no_gap", 32'(gap_cnt), 32'h0);

    // Impulse in the lowest message position.
    for (int i = 0; i < 250; i++) src_q.push_back(8'h00);
    src_q.push_back(8'h01);
    stream(100, 100, t);
    chk("impulse_parity", {last_par[0], last_par[1], last_par[2], last_par[3]}, 32'h0F367840);

    // Directed vectors on the N=8 encoder.
    use_dut(1'b1);
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) src_q.push_back(tbl[v].msg[31 - 8*i -: 8]);
      stream(100, 100, t);
      chk($sformatf("vector%0d_parity", v),
          {last_par[0], last_par[1], last_par[2], last_par[3]}, tbl[v].par);
    end

    // Back-to-back random codewords, N=8 then N=255.
    for (int i = 0; i < 100 * 4; i++) src_q.push_back(8'($urandom));
    gap_cnt = 0;
    x = cw_cnt;
    stream(100, 100, t);
    chk("n8_b2b_cycles", 32'(t), 32'(100 * 8 + 1));
    chk("n8_b2b_codewords", 32'(cw_cnt - x), 32'd100);
    chk("n8_b2b_no_gap", 32'(gap_cnt), 32'h0);

    use_dut(1'b0);
    for (int i = 0; i < 100 * 251; i++) src_q.push_back(8'($urandom));
    gap_cnt = 0;
    x = cw_cnt;
    stream(100, 100, t);
    chk("n255_b2b_cycles", 32'(t), 32'(100 * 255 + 1));
    chk("n255_b2b_codewords", 32'(cw_cnt - x), 32'd100);
    chk("n255_b2b_no_gap", 32'(gap_cnt), 32'h0);

    // Random backpressure and sparse input.
    x = cw_cnt;
    for (int i = 0; i < 6 * 251; i++) src_q.push_back(8'($urandom));
    stream(50, 50, t);
    chk("n255_stall_codewords", 32'(cw_cnt - x), 32'd6);
    use_dut(1'b1);
    x = cw_cnt;
    for (int i = 0; i < 60 * 4; i++) src_q.push_back(8'($urandom));
    stream(50, 50, t);
    chk("n8_stall_codewords", 32'(cw_cnt - x), 32'd60);

    // Reset after 100 message symbols aborts the codeword.
    use_dut(1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    exp_q.delete();
    msg_q.delete();
    rx_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 250; i++) src_q.push_back(8'h00);
    src_q.push_back(8'h01);
    stream(100, 100, t);
    chk("post_rst_impulse_parity", {last_par[0], last_par[1], last_par[2], last_par[3]},
        32'h0F367840);
    chk("post_rst_cycles", 32'(t), 32'(255 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
